// File: rtl/user_io_stepper.sv
// user_io_stepper: Wishbone-controlled input mux and single-step pulse
// generator in front of user_module, with capture of its output after
// every generated pulse.
module user_io_stepper #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned HALF      = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [7:0]  pad_in,
  output logic [7:0]  user_in,
  input  logic [7:0]  user_out,
  output logic        done_irq
);

  localparam int unsigned PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF - 1);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_DIN    = 8'h04;
  localparam logic [7:0] OFF_STEP   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_DOUT   = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Bus-side registers
  logic        ack_q;
  logic [31:0] dat_q;
  logic        wr_en_q;
  logic [7:0]  wr_adr_q;
  logic [15:0] wr_dat_q;
  logic [1:0]  wr_sel_q;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:2]  din_q, din_d;
  logic        ovr_q, ovr_d;

  // Step engine registers
  state_e      state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  dout_q, dout_d;
  logic        irq_q, irq_d;

  logic        dec_c;
  logic [31:0] rd_data_c;
  logic        busy_c;
  logic        clk_gen_c;
  logic        wr_ctrl_c;
  logic        wr_step_c;
  logic [15:0] step_n_c;
  logic        step_accept_c;
  logic        step_ovr_c;
  logic        abort_c;

  // Upper data bits and lanes are never stored by any register here.
  logic unused_ok;
  assign unused_ok = &{1'b0, wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // Address decode; no new decode in the ack cycle so a held strobe gets one ack
  assign dec_c = wbs_stb_i & wbs_cyc_i & ~ack_q &
                 (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  // Write qualifiers, applied at the edge that closes the ack cycle
  always_comb begin
    wr_ctrl_c     = wr_en_q && (wr_adr_q == OFF_CTRL) && wr_sel_q[0];
    wr_step_c     = wr_en_q && (wr_adr_q == OFF_STEP);
    step_n_c      = {wr_sel_q[1] ? wr_dat_q[15:8] : 8'h00,
                     wr_sel_q[0] ? wr_dat_q[7:0]  : 8'h00};
    step_accept_c = wr_step_c && ctrl_q[0] && !busy_c && (step_n_c != 16'd0);
    step_ovr_c    = wr_step_c && ctrl_q[0] && busy_c;
    abort_c       = wr_ctrl_c && !wr_dat_q[0] && busy_c;
  end

  // Read mux, sampled at decode so data is presented with ack
  always_comb begin
    rd_data_c = 32'd0;
    case (wbs_adr_i[7:0])
      OFF_CTRL:   rd_data_c = {30'd0, ctrl_q};
      OFF_DIN:    rd_data_c = {24'd0, din_q, 2'b00};
      OFF_STEP:   rd_data_c = {16'd0, count_q};
      OFF_STATUS: rd_data_c = {30'd0, ovr_q, busy_c};
      OFF_DOUT:   rd_data_c = {24'd0, dout_q};
      default:    rd_data_c = 32'd0;
    endcase
  end

  // Next value of the firmware control registers
  always_comb begin
    ctrl_d = ctrl_q;
    din_d  = din_q;
    ovr_d  = ovr_q;
    if (wr_ctrl_c) ctrl_d = wr_dat_q[1:0];
    if (wr_en_q && (wr_adr_q == OFF_DIN) && wr_sel_q[0]) din_d = wr_dat_q[7:2];
    if (step_ovr_c) ovr_d = 1'b1;
    if (wr_en_q && (wr_adr_q == OFF_STATUS) && wr_sel_q[0] && wr_dat_q[1]) ovr_d = 1'b0;
  end

  // Wishbone handshake, write-request capture and control registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      wr_en_q  <= 1'b0;
      wr_adr_q <= 8'd0;
      wr_dat_q <= 16'd0;
      wr_sel_q <= 2'd0;
      ctrl_q   <= 2'd0;
      din_q    <= 6'd0;
      ovr_q    <= 1'b0;
    end else begin
      ack_q    <= dec_c;
      dat_q    <= dec_c ? rd_data_c : 32'd0;
      wr_en_q  <= dec_c & wbs_we_i;
      wr_adr_q <= wbs_adr_i[7:0];
      wr_dat_q <= wbs_dat_i[15:0];
      wr_sel_q <= wbs_sel_i[1:0];
      ctrl_q   <= ctrl_d;
      din_q    <= din_d;
      ovr_q    <= ovr_d;
    end
  end

  // Step FSM state register together with its phase/count/capture datapath
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      count_q <= 16'd0;
      dout_q  <= 8'd0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      irq_q   <= irq_d;
    end
  end

  // Step FSM next state: HALF cycles high, HALF cycles low, capture at end of low
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    dout_d  = dout_q;
    irq_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (step_accept_c) begin
          state_d = ST_HIGH;
          phase_d = PHASE_LAST;
          count_d = step_n_c;
        end
      end
      ST_HIGH: begin
        if (phase_q == '0) begin
          state_d = ST_LOW;
          phase_d = PHASE_LAST;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      ST_LOW: begin
        if (phase_q == '0) begin
          dout_d  = user_out;
          count_d = (count_q != 16'd0) ? count_q - 16'd1 : 16'd0;
          if (count_q <= 16'd1) begin
            state_d = ST_IDLE;
            irq_d   = 1'b1;
          end else begin
            state_d = ST_HIGH;
            phase_d = PHASE_LAST;
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Switching back to pads mid-burst drops the burst silently
    if (abort_c) begin
      state_d = ST_IDLE;
      phase_d = '0;
      count_d = 16'd0;
      dout_d  = dout_q;
      irq_d   = 1'b0;
    end
  end

  // Step FSM outputs and the user_module input mux
  always_comb begin
    busy_c    = (state_q != ST_IDLE);
    clk_gen_c = (state_q == ST_HIGH);
    user_in   = ctrl_q[0] ? {din_q, ctrl_q[1], clk_gen_c} : pad_in;
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign done_irq  = irq_q;

endmodule

// File: tb/tb_user_io_stepper.sv
// Directed/randomised bench for user_io_stepper with an arithmetic model of
// the pulse train, remaining count and captured output.
module tb_user_io_stepper;

  localparam int unsigned HALF = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [7:0] A_CTRL = 8'h00, A_DIN = 8'h04, A_STEP = 8'h08,
                         A_STAT = 8'h0C, A_DOUT = 8'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  pad_in, user_in, user_out;
  logic        done_irq;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic        m_sel = 1'b0, m_urst = 1'b0;
  logic [7:0]  m_din = 8'h00;

  // Free-running cycle counter and pulse counter feeding user_out
  logic [31:0] cyc_n = 32'd0;
  logic [7:0]  pcnt = 8'd0;
  logic        pprev = 1'b0;
  logic        pc_clr = 1'b0;
  logic [7:0]  omask = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 32'd1;

  always @(negedge clk) begin
    if (pc_clr) begin
      pcnt  <= 8'd0;
      pprev <= 1'b0;
    end else begin
      pprev <= user_in[0];
      if (user_in[0] && !pprev) pcnt <= pcnt + 8'd1;
    end
  end

  assign user_out = pcnt ^ omask;

  user_io_stepper #(.BASE_ADDR(BASE), .HALF(HALF)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .pad_in   (pad_in),
    .user_in  (user_in),
    .user_out (user_out),
    .done_irq (done_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] idle_user_in();
    return m_sel ? {m_din[7:2], m_urst, 1'b0} : pad_in;
  endfunction

  // Single Wishbone access; returns read data and the cycle number of the ack cycle
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output logic [31:0] ack_cyc);
    bit got;
    got = 1'b0;
    rd = 32'd0;
    ack_cyc = 32'd0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        rd = rdat;
        ack_cyc = cyc_n;
        break;
      end
    end
    chk("wb_ack_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, output logic [31:0] ack_cyc);
    logic [31:0] dummy;
    wb_access(1'b1, BASE | 32'(off), d, 4'hF, dummy, ack_cyc);
  endtask

  task automatic wb_rd(input logic [7:0] off, output logic [31:0] d, output logic [31:0] ack_cyc);
    wb_access(1'b0, BASE | 32'(off), 32'd0, 4'hF, d, ack_cyc);
  endtask

  task automatic clear_pulses(input logic [7:0] mask);
    omask  = mask;
    pc_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pc_clr = 1'b0;
  endtask

  // Full burst: cycle-by-cycle pulse train and irq, then register readback
  task automatic run_burst(input int n, input logic [7:0] mask);
    logic [31:0] ac, d;
    int total;
    logic exp_clk;
    total = 2 * int'(HALF) * n;
    clear_pulses(mask);
    wb_wr(A_STEP, 32'(n), ac);
    for (int k = 0; k < total + 3; k++) begin
      @(negedge clk);
      exp_clk = (k < total) && ((k % (2 * int'(HALF))) < int'(HALF));
      chk($sformatf("burst%0d_user_in_k%0d", n, k), 32'(user_in),
          32'({m_din[7:2], m_urst, exp_clk}));
      chk($sformatf("burst%0d_irq_k%0d", n, k), 32'(done_irq), 32'(k == total));
    end
    wb_rd(A_STEP, d, ac);
    chk("burst_step_after", d, 32'd0);
    wb_rd(A_STAT, d, ac);
    chk("burst_status_after", d, 32'd0);
    wb_rd(A_DOUT, d, ac);
    chk("burst_dout", d, 32'(8'(n) ^ mask));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d, ac, a0, a_rd;
    int start, k, n;
    bit got;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'd0; wdat = 32'd0; pad_in = 8'hA5;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_user_in", 32'(user_in), 32'h0000_00A5);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", 32'(done_irq), 32'd0);
    for (int i = 0; i < 5; i++) begin
      wb_rd(8'(4 * i), d, ac);
      chk($sformatf("rst_reg_%0h", 4 * i), d, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      pad_in = 8'($urandom);
      #1;
      chk("pad_passthru", 32'(user_in), 32'(pad_in));
    end

    // Firmware drive of user_in
    wb_wr(A_CTRL, 32'h3, ac); m_sel = 1'b1; m_urst = 1'b1;
    wb_wr(A_DIN, 32'hFC, ac); m_din = 8'hFC;
    @(negedge clk);
    chk("fw_user_in_FE", 32'(user_in), 32'h0000_00FE);
    wb_wr(A_CTRL, 32'h1, ac); m_urst = 1'b0;
    @(negedge clk);
    chk("fw_user_in_FC", 32'(user_in), 32'h0000_00FC);
    wb_rd(A_DIN, d, ac);
    chk("din_read", d, 32'h0000_00FC);
    wb_rd(A_CTRL, d, ac);
    chk("ctrl_read", d, 32'h1);
    // Byte lane disabled: DIN keeps its value
    wb_access(1'b1, BASE | 32'(A_DIN), 32'h0, 4'h0, d, ac);
    wb_rd(A_DIN, d, ac);
    chk("din_sel_masked", d, 32'h0000_00FC);

    // Held strobe gets one ack; data returns to zero after it
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'(A_DIN);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    chk("held_ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("held_no_reack", 32'(ack), 32'd0);
    chk("held_dat_zero", rdat, 32'd0);
    stb = 1'b0; cyc = 1'b0;

    // Address outside the window is never acked
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0100; wdat = 32'h3; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("foreign_adr_no_ack", 32'(ack), 32'd0);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    wb_rd(A_CTRL, d, ac);
    chk("foreign_no_effect", d, 32'h1);

    // Directed bursts
    run_burst(3, 8'h00);
    run_burst(5, 8'h00);

    // Randomised bursts with random DIN/URST and output mask
    for (int r = 0; r < 4; r++) begin
      m_din  = {6'($urandom), 2'b00};
      m_urst = 1'($urandom);
      wb_wr(A_DIN, 32'(m_din), ac);
      wb_wr(A_CTRL, {30'd0, m_urst, 1'b1}, ac);
      n = int'($urandom_range(1, 6));
      run_burst(n, 8'($urandom));
    end

    // Overrun: second STEP while busy
    clear_pulses(8'h00);
    wb_wr(A_STEP, 32'd4, a0);
    start = int'(a0) + 1;
    wb_wr(A_STEP, 32'd4, ac);
    wb_rd(A_STAT, d, a_rd);
    k = int'(a_rd) - 1 - start;
    chk("ovr_status_busy", d, {30'd0, 1'b1, 1'(k < 16)});
    wb_rd(A_STEP, d, a_rd);
    k = int'(a_rd) - 1 - start;
    chk("ovr_count_kept", d, 32'(4 - k / (2 * int'(HALF))));
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done_irq) begin
        got = 1'b1;
        chk("ovr_irq_cycle", cyc_n - 32'(start), 32'd16);
      end
    end
    chk("ovr_irq_seen", 32'(got), 32'd1);
    wb_rd(A_STAT, d, ac);
    chk("ovr_sticky", d, 32'h2);
    wb_rd(A_DOUT, d, ac);
    chk("ovr_dout", d, 32'h4);
    wb_wr(A_STAT, 32'h2, ac);
    wb_rd(A_STAT, d, ac);
    chk("ovr_cleared", d, 32'h0);

    // N=0 is a no-op
    wb_wr(A_STEP, 32'd0, ac);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("n0_irq", 32'(done_irq), 32'd0);
      chk("n0_user_in", 32'(user_in), 32'(idle_user_in()));
    end
    wb_rd(A_STAT, d, ac);
    chk("n0_status", d, 32'd0);

    // STEP ignored in pad mode
    wb_wr(A_CTRL, 32'h0, ac); m_sel = 1'b0;
    wb_wr(A_STEP, 32'd3, ac);
    for (int i = 0; i < 6; i++) begin
      pad_in = 8'($urandom);
      @(negedge clk);
      chk("padmode_irq", 32'(done_irq), 32'd0);
      chk("padmode_user_in", 32'(user_in), 32'(pad_in));
    end
    wb_rd(A_STEP, d, ac);
    chk("padmode_count", d, 32'd0);

    // Abort after two full pulses
    wb_wr(A_CTRL, {30'd0, m_urst, 1'b1}, ac); m_sel = 1'b1;
    clear_pulses(8'h00);
    wb_wr(A_STEP, 32'd10, ac);
    for (int kk = 0; kk < 8; kk++) begin
      @(negedge clk);
      chk("abort_pre_clk", 32'(user_in[0]), 32'((kk % 4) < 2));
    end
    wb_wr(A_CTRL, 32'h0, ac); m_sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_irq", 32'(done_irq), 32'd0);
      chk("abort_user_in_pad", 32'(user_in), 32'(pad_in));
    end
    wb_rd(A_STAT, d, ac);
    chk("abort_status", d, 32'd0);
    wb_rd(A_STEP, d, ac);
    chk("abort_count", d, 32'd0);
    wb_rd(A_DOUT, d, ac);
    chk("abort_dout", d, 32'h2);

    // Reset mid-burst
    wb_wr(A_CTRL, 32'h1, ac); m_sel = 1'b1; m_urst = 1'b0;
    wb_wr(A_STEP, 32'd5, ac);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    pad_in = 8'h3C;
    @(negedge clk);
    chk("midrst_user_in", 32'(user_in), 32'h0000_003C);
    chk("midrst_irq", 32'(done_irq), 32'd0);
    rst = 1'b0; m_sel = 1'b0; m_din = 8'h00;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("midrst_no_irq", 32'(done_irq), 32'd0);
    end
    wb_rd(A_STAT, d, ac);
    chk("midrst_status", d, 32'd0);
    wb_rd(A_DOUT, d, ac);
    chk("midrst_dout", d, 32'd0);
    wb_rd(A_CTRL, d, ac);
    chk("midrst_ctrl", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
